rng_block_qualifier: RTL and testbench

Downstream stage of the PUF randomness statistical test bank (cumulative sums, frequency, runs). Tracks the same N-bit block framing as the tests, samples their per-block `pass` levels at a fixed latency after each block's last bit, and keeps a consecutive-failure count with a sticky alarm. Also packs the raw bit stream into W-bit words and releases them through a valid/ready port only while the source is qualified healthy.

---
 rtl/rng_health_pkg.sv | 33 +++
 rtl/rng_word_packer.sv | 73 +++++++
 rtl/rng_block_qualifier.sv | 171 +++++++++++++++++
 tb/tb_rng_block_qualifier.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_health_pkg.sv
// -----------------------------------------------------------------------------
// rng_health_pkg
// Shared types and constants for the PUF randomness health-qualification path.
//   DEFAULT_BLOCK_N : bits per statistical-test block (must match the tests)
//   FAIL_RUN_W      : width of the consecutive-failure counter
//   MAX_TESTS       : widest pass vector the verdict struct can carry
//   verdict_t       : evaluated block verdict (ok flag + per-test fail mask)
// -----------------------------------------------------------------------------
package rng_health_pkg;

    localparam int DEFAULT_BLOCK_N = 20000;
    localparam int FAIL_RUN_W      = 8;
    localparam int MAX_TESTS       = 16;

    typedef struct packed {
        logic                 ok;
        logic [MAX_TESTS-1:0] mask;
    } verdict_t;

    // Unused test lanes are padded with 1 by the caller, so they can never
    // show up as failures and never spoil the ok flag.
    function automatic verdict_t eval_verdict(input logic [MAX_TESTS-1:0] pass_ext);
        verdict_t v;
        v.mask = ~pass_ext;
        v.ok   = ~|v.mask;
        return v;
    endfunction

    function automatic logic [FAIL_RUN_W-1:0] sat_inc(input logic [FAIL_RUN_W-1:0] x);
        return (&x) ? x : x + 1'b1;
    endfunction

endpackage

// File: rtl/rng_word_packer.sv
// -----------------------------------------------------------------------------
// rng_word_packer
// Packs a serial bit stream LSB-first into W-bit words and presents them on a
// single-entry valid/ready holding register. Completed words are discarded
// while keep is low; a completed word that finds the holding register occupied
// (and not being accepted) is dropped and sets the sticky overrun flag.
// Ports:
//   clk, rst (sync, active-high)
//   bit_in    : one raw bit per cycle
//   keep      : source qualified healthy; completed words are offered only then
//   out_data  : held word, stable while out_valid && !out_ready
//   out_valid : holding register full
//   out_ready : downstream accepts on the edge where out_valid && out_ready
//   overrun   : sticky, a completed word was lost to a full holding register
// -----------------------------------------------------------------------------
module rng_word_packer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bit_in,
    input  logic         keep,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         overrun
);

    localparam int PW = $clog2(W);

    logic [PW-1:0] bit_cnt;
    logic [W-2:0]  shreg;      // the W-1 bits received before the current one
    logic [W-1:0]  word_next;  // word as it would look if completed this edge
    logic          word_done;
    logic          accept;
    logic          can_load;

    assign word_next = {bit_in, shreg};
    assign word_done = (bit_cnt == PW'(W - 1));
    assign accept    = out_valid && out_ready;
    // An accept on this edge frees the slot, so load and accept can coincide.
    assign can_load  = !out_valid || out_ready;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
            shreg   <= word_next[W-1:1];

            if (word_done && keep && can_load) begin
                out_data  <= word_next;
                out_valid <= 1'b1;
            end else begin
                if (accept) begin
                    out_valid <= 1'b0;
                end
                // Reaching here with a kept word means the slot was full and
                // not draining.
                if (word_done && keep) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rng_block_qualifier.sv
// -----------------------------------------------------------------------------
// rng_block_qualifier
// Downstream stage of the PUF randomness test bank. Mirrors the tests' N-bit
// block framing, samples their pass levels VERDICT_LAT cycles after each
// block's last bit, tracks consecutive failures with a sticky alarm, and
// releases packed raw words only while the source is qualified healthy.
//
// Build option: define RNG_QUAL_STATS_EN to add the blocks_total /
// blocks_failed evaluated-verdict counters (cleared by rst only).
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   rand_bit        : raw bit, one per cycle (same stream the tests see)
//   pass            : per-test pass levels
//   alarm_clr       : clears alarm and fail_run
//   verdict_valid   : one-cycle strobe per evaluated block
//   verdict_ok      : last sampled pass vector was all ones
//   fail_mask       : inverted last sampled pass vector
//   fail_run        : consecutive failed verdicts, saturating at 255
//   alarm           : sticky health alarm
//   out_data/out_valid/out_ready : packed-word handshake
//   overrun         : sticky, a completed word was dropped
//   blocks_total, blocks_failed  : (RNG_QUAL_STATS_EN only) saturating counts
// -----------------------------------------------------------------------------
module rng_block_qualifier
    import rng_health_pkg::*;
#(
    parameter int N             = DEFAULT_BLOCK_N,
    parameter int NUM_TESTS     = 3,
    parameter int VERDICT_LAT   = 3,
    parameter int MAX_FAIL      = 3,
    parameter int WARMUP_BLOCKS = 1,
    parameter int W             = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rand_bit,
    input  logic [NUM_TESTS-1:0]  pass,
    input  logic                  alarm_clr,
    output logic                  verdict_valid,
    output logic                  verdict_ok,
    output logic [NUM_TESTS-1:0]  fail_mask,
    output logic [FAIL_RUN_W-1:0] fail_run,
    output logic                  alarm,
    output logic [W-1:0]          out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun
`ifdef RNG_QUAL_STATS_EN
    ,
    output logic [15:0]           blocks_total,
    output logic [15:0]           blocks_failed
`endif
);

    localparam int CW = $clog2(N);

    logic [CW-1:0]         bit_cnt;
    logic                  block_seen;   // at least one full block since reset
    logic [3:0]            warm_cnt;
    logic                  warm_done;
    logic                  sample;
    logic                  evaluate;
    logic [MAX_TESTS-1:0]  pass_ext;
    verdict_t              v_new;
    verdict_t              verdict_q;
    logic [FAIL_RUN_W-1:0] run_inc;
    logic                  alarm_set;
    logic                  healthy;

    // NOTE: every variable assigned in always_comb gets a full default first,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        pass_ext                = '1;
        pass_ext[NUM_TESTS-1:0] = pass;
    end

    assign v_new = eval_verdict(pass_ext);

    // VERDICT_LAT < N, so the sample edge always falls at bit VERDICT_LAT-1 of
    // the following block; block_seen suppresses that point in the very first
    // block, which has no predecessor.
    assign sample    = block_seen && (bit_cnt == CW'(VERDICT_LAT - 1));
    assign warm_done = (warm_cnt == 4'(WARMUP_BLOCKS));
    assign evaluate  = sample && warm_done;

    assign run_inc   = sat_inc(fail_run);
    assign alarm_set = !v_new.ok && (run_inc >= FAIL_RUN_W'(MAX_FAIL));

    assign healthy    = warm_done && verdict_q.ok && !alarm;
    assign verdict_ok = verdict_q.ok;
    assign fail_mask  = NUM_TESTS'(verdict_q.mask);

    // NOTE: only control and status registers exist here, and all of them are
    // reset; the packer's data path is cleared too so out_data reads 0 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt       <= '0;
            block_seen    <= 1'b0;
            warm_cnt      <= '0;
            verdict_valid <= 1'b0;
            verdict_q     <= '0;
            fail_run      <= '0;
            alarm         <= 1'b0;
        end else begin
            bit_cnt <= (bit_cnt == CW'(N - 1)) ? '0 : bit_cnt + 1'b1;
            if (bit_cnt == CW'(N - 1)) begin
                block_seen <= 1'b1;
            end

            verdict_valid <= evaluate;

            // Warm-up verdicts are swallowed without touching health state.
            if (sample && !warm_done) begin
                warm_cnt <= warm_cnt + 1'b1;
            end

            if (evaluate) begin
                verdict_q <= v_new;
                if (v_new.ok) begin
                    fail_run <= '0;
                    if (alarm_clr) begin
                        alarm <= 1'b0;
                    end
                end else if (alarm_set) begin
                    // An alarm-setting verdict beats a coincident clear.
                    fail_run <= run_inc;
                    alarm    <= 1'b1;
                end else if (alarm_clr) begin
                    fail_run <= '0;
                    alarm    <= 1'b0;
                end else begin
                    fail_run <= run_inc;
                end
            end else if (alarm_clr) begin
                fail_run <= '0;
                alarm    <= 1'b0;
            end
        end
    end

`ifdef RNG_QUAL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            blocks_total  <= '0;
            blocks_failed <= '0;
        end else if (evaluate) begin
            if (~&blocks_total) begin
                blocks_total <= blocks_total + 16'd1;
            end
            if (!v_new.ok && ~&blocks_failed) begin
                blocks_failed <= blocks_failed + 16'd1;
            end
        end
    end
`endif

    rng_word_packer #(
        .W (W)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (rand_bit),
        .keep      (healthy),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_rng_block_qualifier.sv
// -----------------------------------------------------------------------------
// tb_rng_block_qualifier
// Self-checking bench for rng_block_qualifier (N=64, W=8, VERDICT_LAT=3,
// MAX_FAIL=3, WARMUP_BLOCKS=1). A behavioural model tracks cycle index since
// reset, verdict count and a queue of received bits; every cycle all outputs
// are compared against it. Directed phases pin the model with literal values.
// -----------------------------------------------------------------------------
module tb_rng_block_qualifier;

    localparam int N   = 64;
    localparam int NT  = 3;
    localparam int VL  = 3;
    localparam int MF  = 3;
    localparam int WU  = 1;
    localparam int W   = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rand_bit;
    logic [NT-1:0] pass;
    logic          alarm_clr;
    logic          out_ready;
    logic          verdict_valid;
    logic          verdict_ok;
    logic [NT-1:0] fail_mask;
    logic [7:0]    fail_run;
    logic          alarm;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          overrun;
`ifdef RNG_QUAL_STATS_EN
    logic [15:0]   blocks_total;
    logic [15:0]   blocks_failed;
`endif

    always #5 clk = ~clk;

    rng_block_qualifier #(
        .N(N), .NUM_TESTS(NT), .VERDICT_LAT(VL), .MAX_FAIL(MF),
        .WARMUP_BLOCKS(WU), .W(W)
    ) dut (
        .clk(clk), .rst(rst), .rand_bit(rand_bit), .pass(pass),
        .alarm_clr(alarm_clr), .verdict_valid(verdict_valid),
        .verdict_ok(verdict_ok), .fail_mask(fail_mask), .fail_run(fail_run),
        .alarm(alarm), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .overrun(overrun)
`ifdef RNG_QUAL_STATS_EN
        , .blocks_total(blocks_total), .blocks_failed(blocks_failed)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          k;        // index of the cycle that ends at the next edge
    int          nverd;    // warm-up verdicts consumed
    bit          m_vv, m_ok, m_alarm, m_ov, m_ovr;
    bit [NT-1:0] m_mask;
    int          m_run;
    bit [W-1:0]  m_od;
    bit          bits_q[$];
    int          m_tot, m_fl;

    // True when the edge ending cycle k lies VL cycles after some block's last bit.
    function automatic bit sample_next();
        int s = k - (N - 1) - VL;
        return (s >= 0) && (s % N == 0);
    endfunction

    function automatic void model_edge();
        bit         healthy;
        bit         smp;
        bit         eval;
        bit [W-1:0] word;
        int         nr;
        if (rst) begin
            k = 0; nverd = 0; m_vv = 0; m_ok = 0; m_mask = '0; m_run = 0;
            m_alarm = 0; m_ov = 0; m_ovr = 0; m_od = '0; bits_q.delete();
            m_tot = 0; m_fl = 0;
            return;
        end
        healthy = (nverd >= WU) && m_ok && !m_alarm;
        smp  = sample_next();
        eval = smp && (nverd >= WU);
        if (smp && nverd < WU) nverd++;
        m_vv = eval;
        if (eval) begin
            nr     = (m_run < 255) ? m_run + 1 : 255;
            m_ok   = (pass == '1);
            m_mask = ~pass;
            if (m_tot < 65535) m_tot++;
            if (!m_ok && m_fl < 65535) m_fl++;
            if (m_ok) begin
                m_run = 0;
                if (alarm_clr) m_alarm = 0;
            end else if (nr >= MF) begin
                m_run = nr; m_alarm = 1;
            end else if (alarm_clr) begin
                m_run = 0; m_alarm = 0;
            end else begin
                m_run = nr;
            end
        end else if (alarm_clr) begin
            m_run = 0; m_alarm = 0;
        end
        bits_q.push_back(rand_bit);
        if (bits_q.size() == W) begin
            for (int i = 0; i < W; i++) word[i] = bits_q[i];
            bits_q.delete();
            if (!healthy) begin
                if (m_ov && out_ready) m_ov = 0;
            end else if (!m_ov || out_ready) begin
                m_od = word; m_ov = 1;
            end else begin
                m_ovr = 1;
            end
        end else if (m_ov && out_ready) begin
            m_ov = 0;
        end
        k++;
    endfunction

    task automatic compare();
        check("verdict_valid", verdict_valid, m_vv);
        check("verdict_ok", verdict_ok, m_ok);
        check("fail_mask", fail_mask, m_mask);
        check("fail_run", fail_run, m_run);
        check("alarm", alarm, m_alarm);
        check("out_valid", out_valid, m_ov);
        if (m_ov) check("out_data", out_data, m_od);
        check("overrun", overrun, m_ovr);
`ifdef RNG_QUAL_STATS_EN
        check("blocks_total", blocks_total, m_tot);
        check("blocks_failed", blocks_failed, m_fl);
`endif
    endtask

    task automatic tick();
        rand_bit = 1'($urandom_range(0, 1));
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic wait_vv(input int budget, input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!verdict_valid && n < budget);
        check({name, "_reached"}, verdict_valid, 1'b1);
    endtask

    logic [W-1:0] held;
    bit           held_seen;
    int           n;

    initial begin
        rst = 1'b1; rand_bit = 1'b0; pass = '1; alarm_clr = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // First strobe: warm-up block 0 swallowed, block 1 evaluated. Counting
        // the first post-reset cycle as 1, the strobe is in cycle 64*2+3+1,
        // i.e. visible after 131 edges.
        wait_vv(400, "first_strobe");
        check("first_strobe_cycle", k, 2 * N + VL);
        check("first_verdict_ok", verdict_ok, 1'b1);
        n = 0;
        while (!out_valid && n < 2 * W) begin tick(); n++; end
        check("first_word_out", out_valid, 1'b1);
        repeat (3 * N) tick();

        // Three failing blocks with pass=101.
        pass = 3'b101;
        for (int i = 1; i <= 3; i++) begin
            wait_vv(N + 4, "fail_strobe");
            check("fail_mask_010", fail_mask, 3'b010);
            check("fail_run_step", fail_run, 8'(i));
            check("alarm_on_third", alarm, (i == 3));
            if (i >= 2) check("no_word_after_fail", out_valid, 1'b0);
        end

        // OK verdict clears fail_run but alarm stays sticky; lone clr clears it.
        pass = '1;
        wait_vv(N + 4, "ok_strobe");
        check("run_after_ok", fail_run, 8'd0);
        check("alarm_sticky", alarm, 1'b1);
        alarm_clr = 1'b1; tick(); alarm_clr = 1'b0;
        check("alarm_cleared", alarm, 1'b0);

        // alarm_clr on the same edge as the third failure: set wins.
        pass = 3'b101;
        wait_vv(N + 4, "fail_a");
        wait_vv(N + 4, "fail_b");
        check("run_two", fail_run, 8'd2);
        n = 0;
        while (!sample_next() && n < N + 4) begin tick(); n++; end
        alarm_clr = 1'b1; tick(); alarm_clr = 1'b0;
        check("coincide_strobe", verdict_valid, 1'b1);
        check("coincide_alarm", alarm, 1'b1);
        check("coincide_run", fail_run, 8'd3);
        repeat (5) tick();
        alarm_clr = 1'b1; tick(); alarm_clr = 1'b0;
        check("solo_clr_alarm", alarm, 1'b0);
        check("solo_clr_run", fail_run, 8'd0);

        // Back-pressure: hold out_ready low for 20 cycles while healthy.
        pass = '1;
        wait_vv(N + 4, "recover");
        check("recovered_ok", verdict_ok, 1'b1);
        out_ready = 1'b0;
        held_seen = 1'b0;
        held = '0;
        for (int i = 0; i < 20; i++) begin
            if (!held_seen && out_valid) begin held = out_data; held_seen = 1'b1; end
            tick();
        end
        check("held_valid", out_valid, 1'b1);
        check("held_stable", out_data, held);
        check("overrun_set", overrun, 1'b1);
        out_ready = 1'b1;
        check("held_at_accept", out_data, held);
        tick();

        // Reset in bit 30 of block 2, then a 5-verdict run with two failures.
        rst = 1'b1; tick(); rst = 1'b0;
        n = 0;
        while (k != 2 * N + 30 && n < 4 * N) begin tick(); n++; end
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_vv", verdict_valid, 1'b0);
        check("rst_ok", verdict_ok, 1'b0);
        check("rst_mask", fail_mask, 3'b000);
        check("rst_run", fail_run, 8'd0);
        check("rst_alarm", alarm, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_overrun", overrun, 1'b0);
        wait_vv(400, "post_rst_strobe");
        check("post_rst_strobe_cycle", k, 2 * N + VL);
        for (int i = 2; i <= 5; i++) begin
            pass = (i == 2 || i == 4) ? 3'b011 : 3'b111;
            wait_vv(N + 4, "stats_strobe");
        end
`ifdef RNG_QUAL_STATS_EN
        check("stats_total_5", blocks_total, 16'd5);
        check("stats_failed_2", blocks_failed, 16'd2);
`endif

        // Randomised traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0)
                pass = ($urandom_range(0, 1) == 0) ? 3'b111 : 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            alarm_clr = ($urandom_range(0, 99) == 0);
            rst       = ($urandom_range(0, 1999) == 0);
            tick();
        end
        rst = 1'b0; alarm_clr = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
